ps2_key_decoder: RTL and testbench

Upstream input stage for the 2048 top level. It replaces the temporary SW[4:0] inputs with a PS/2 keyboard.
- Receives PS/2 serial frames and assembles scan-code set 2 bytes.
- Tracks make, break and extended (E0) prefixes.
- Drives the same start and direction[3:0] (up, down, left, right) levels that the control block and the box reset consume.

---
 rtl/ps2_key_decoder_pkg.sv | 30 +++
 rtl/ps2_key_decoder_if.sv | 22 ++
 rtl/ps2_key_decoder_rx_frame.sv | 135 +++++++++++++
 rtl/ps2_key_decoder.sv | 91 +++++++++
 tb/tb_ps2_key_decoder.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants, direction bit indices and frame states
// for the PS/2 keyboard input stage.
package ps2_codes;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_S     = 8'h1B;

  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // Odd parity holds when data and parity bit XOR to 1.
  function automatic logic odd_ok(logic [7:0] d, logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Byte bus from the PS/2 frame receiver to the key decoder.
// All strobes are single-cycle and mutually exclusive.
interface ps2_key_decoder_if;
  logic [7:0] data;
  logic       byte_valid;
  logic       err;
  logic       abort;

  modport master (
    output data,
    output byte_valid,
    output err,
    output abort
  );

  modport slave (
    input data,
    input byte_valid,
    input err,
    input abort
  );
endinterface

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 receiver: sync, clock filter, falling-edge detect,
// 11-bit frame FSM with parity/stop check and inter-edge timeout.
module ps2_rx_frame
  import ps2_codes::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  ps2_key_decoder_if.master rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [FW-1:0] flt_cnt;
  logic          flt;
  logic          flt_d;
  logic          fall;
  logic          bit_in;

  rx_state_t     state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par, par_n;
  logic [TW-1:0] to_cnt, to_cnt_n;

  // Two-flop synchronizers; lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Filtered clock flips after FILTER_LEN differing samples in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt     <= 1'b1;
      flt_d   <= 1'b1;
      flt_cnt <= '0;
    end else begin
      flt_d <= flt;
      if (clk_sync[1] == flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_MAX) begin
        flt     <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall   = flt_d & ~flt;
  assign bit_in = dat_sync[1];

  // Frame state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      to_cnt  <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par     <= par_n;
      to_cnt  <= to_cnt_n;
    end
  end

  // Next-state, byte issue, error and timeout abort.
  always_comb begin
    state_n       = state;
    bit_cnt_n     = bit_cnt;
    shreg_n       = shreg;
    par_n         = par;
    rx.data       = shreg;
    rx.byte_valid = 1'b0;
    rx.err        = 1'b0;
    rx.abort      = 1'b0;
    if (state == ST_IDLE || fall) begin
      to_cnt_n = '0;
    end else begin
      to_cnt_n = to_cnt + 1'b1;
    end
    if (fall) begin
      unique case (state)
        ST_IDLE: begin
          if (!bit_in) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
        end
        ST_DATA: begin
          shreg_n   = {bit_in, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            state_n = ST_PARITY;
          end
        end
        ST_PARITY: begin
          par_n   = bit_in;
          state_n = ST_STOP;
        end
        ST_STOP: begin
          state_n = ST_IDLE;
          if (bit_in && odd_ok(shreg, par)) begin
            rx.byte_valid = 1'b1;
          end else begin
            rx.err = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && to_cnt == TO_MAX) begin
      state_n  = ST_IDLE;
      rx.abort = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to 2048 controls: prefix tracking, key lookup
// and registered start/direction levels plus strobes.
module ps2_key_decoder
  import ps2_codes::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       start,
  output logic [3:0] direction,
  output logic       key_strobe,
  output logic       frame_err
);

  ps2_key_decoder_if rx_bus ();

  logic       ext;
  logic       brk;
  logic [3:0] hit_dir;
  logic       hit_s;

  ps2_rx_frame #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .ps2_clk (PS2_CLK),
    .ps2_dat (PS2_DAT),
    .rx      (rx_bus.master)
  );

  // Key lookup of the current byte under the extended prefix.
  always_comb begin
    hit_dir = '0;
    hit_s   = 1'b0;
    unique case (1'b1)
      (ext && rx_bus.data == SC_UP):    hit_dir[UP]    = 1'b1;
      (ext && rx_bus.data == SC_DOWN):  hit_dir[DOWN]  = 1'b1;
      (ext && rx_bus.data == SC_LEFT):  hit_dir[LEFT]  = 1'b1;
      (ext && rx_bus.data == SC_RIGHT): hit_dir[RIGHT] = 1'b1;
      (!ext && rx_bus.data == SC_S):    hit_s          = 1'b1;
      default: ;
    endcase
  end

  // Prefix flags and held key levels, updated per committed byte.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      start      <= 1'b0;
      direction  <= '0;
      key_strobe <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      frame_err  <= rx_bus.err;
      if (rx_bus.err || rx_bus.abort) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_bus.byte_valid) begin
        if (rx_bus.data == SC_EXT) begin
          ext <= 1'b1;
        end else if (rx_bus.data == SC_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (hit_dir != '0) begin
            if (!brk) begin
              direction  <= hit_dir;
              key_strobe <= 1'b1;
            end else if ((direction & hit_dir) != '0) begin
              direction <= '0;
            end
          end
          if (hit_s) begin
            start      <= !brk;
            key_strobe <= !brk;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed plus random key events against an event-level model
// of held keys, strobe and error counts.
module tb_ps2_key_decoder;
  import ps2_codes::*;

  localparam int QB  = 25;
  localparam int GAP = 60;

  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       start;
  logic [3:0] direction;
  logic       key_strobe;
  logic       frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  logic [3:0] exp_dir;
  logic       exp_start;
  int         exp_strobe;
  int         exp_err;

  logic [7:0] codes [7];

  ps2_key_decoder #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .start      (start),
    .direction  (direction),
    .key_strobe (key_strobe),
    .frame_err  (frame_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (key_strobe) strobe_cnt <= strobe_cnt + 1;
    if (frame_err) err_cnt <= err_cnt + 1;
    if (key_strobe && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge CLOCK_50);
  endtask

  task automatic send_bit(logic b);
    PS2_DAT = b;
    wait_cyc(QB);
    PS2_CLK = 1'b0;
    wait_cyc(2 * QB);
    PS2_CLK = 1'b1;
    wait_cyc(QB);
  endtask

  task automatic send_byte(logic [7:0] b, logic bad);
    logic p;
    p = (~^b) ^ bad;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    wait_cyc(GAP);
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    @(negedge CLOCK_50);
    check({tag, ".dir"}, 32'(direction), 32'(exp_dir));
    check({tag, ".start"}, 32'(start), 32'(exp_start));
    check({tag, ".strobes"}, strobe_cnt, exp_strobe);
    check({tag, ".errs"}, err_cnt, exp_err);
    check({tag, ".overlap"}, both_cnt, 0);
  endtask

  // k: 0-3 arrows up/down/left/right, 4 S, 5 bare 75, 6 unmapped.
  task automatic key(int k, logic brk);
    logic [3:0] oh;
    if (k < 4) send_byte(SC_EXT, 1'b0);
    if (brk) send_byte(SC_BRK, 1'b0);
    send_byte(codes[k], 1'b0);
    if (k < 4) begin
      oh = 4'b1000 >> k;
      if (!brk) begin
        exp_dir = oh;
        exp_strobe++;
      end else if (exp_dir == oh) begin
        exp_dir = '0;
      end
    end else if (k == 4) begin
      exp_start = !brk;
      if (!brk) exp_strobe++;
    end
  endtask

  initial begin
    int k;
    logic b;
    codes = '{SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_S, SC_UP, 8'h1C};
    exp_dir = '0;
    exp_start = 1'b0;
    exp_strobe = 0;
    exp_err = 0;

    wait_cyc(5);
    check_all("reset");
    resetn = 1'b1;
    wait_cyc(20);

    key(4, 1'b0);
    key(0, 1'b0);
    check_all("pre_reset");
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    resetn = 1'b0;
    exp_dir = '0;
    exp_start = 1'b0;
    wait_cyc(3);
    check_all("mid_reset");
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    wait_cyc(50);
    resetn = 1'b1;
    wait_cyc(50);
    key(0, 1'b0);
    check_all("post_reset_up");

    key(0, 1'b1);
    check_all("up_break");

    key(0, 1'b0);
    key(2, 1'b0);
    check_all("last_wins");
    key(0, 1'b1);
    check_all("stale_break");
    key(2, 1'b1);
    check_all("left_break");

    key(4, 1'b0);
    check_all("s_make");
    key(4, 1'b1);
    check_all("s_break");
    key(5, 1'b0);
    check_all("bare_75");

    key(0, 1'b0);
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_DOWN, 1'b1);
    exp_err++;
    check_all("parity_err");
    send_byte(SC_DOWN, 1'b0);
    check_all("ext_cleared");

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    wait_cyc(1200);
    check_all("timeout");
    key(1, 1'b0);
    check_all("after_timeout");

    for (int n = 0; n < 8; n++) begin
      k = int'($urandom_range(0, 6));
      b = 1'($urandom_range(0, 1));
      key(k, b);
      check_all($sformatf("rand%0d_k%0d_b%0d", n, k, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
